// File: rtl/writeback_unit.sv
// Register-file write-back sequencer: merges unstallable ALU results with
// FIFO-buffered load returns and tracks outstanding writes per register.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [7:0]  alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  chk_ra_addr,
  input  logic [4:0]  chk_rd_addr,
  output logic        stall,
  output logic        en_WD,
  output logic [4:0]  WD_addr,
  output logic [7:0]  WD,
  output logic [31:0] pending,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Handshake: a load transfers on a cycle where mem_valid && mem_ready are
  // both high at the rising edge; mem_ready depends only on registered state.

  logic [12:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [12:0] head;

  logic        launch_valid;
  logic [4:0]  launch_addr;
  logic [7:0]  launch_data;
  logic [31:0] pending_next;
  logic        violation;

  // The extra pointer bit separates full (MSBs differ) from empty (equal).
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign mem_ready  = !fifo_full;
  assign push       = mem_valid && mem_ready;
  assign pop        = !alu_valid && !fifo_empty;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];

  assign stall = pending[chk_ra_addr] | pending[chk_rd_addr] | pending[iss_addr];

  always_comb begin
    launch_valid = 1'b0;
    launch_addr  = 5'd0;
    launch_data  = 8'd0;
    if (alu_valid) begin
      launch_valid = 1'b1;
      launch_addr  = alu_addr;
      launch_data  = alu_data;
    end else if (pop) begin
      launch_valid = 1'b1;
      launch_addr  = head[12:8];
      launch_data  = head[7:0];
    end
  end

  // Clear first so a same-edge set on the same register takes precedence.
  always_comb begin
    pending_next = pending;
    if (en_WD) pending_next[WD_addr] = 1'b0;
    if (iss_valid) pending_next[iss_addr] = 1'b1;
  end

  // A bit being retired on this edge counts as free for a re-issue.
  always_comb begin
    violation = 1'b0;
    if (iss_valid && pending[iss_addr] && !(en_WD && (WD_addr == iss_addr)))
      violation = 1'b1;
    if (launch_valid && !pending[launch_addr])
      violation = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {mem_addr, mem_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      en_WD   <= 1'b0;
      WD_addr <= 5'd0;
      WD      <= 8'd0;
      pending <= 32'd0;
      err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      en_WD <= launch_valid;
      if (launch_valid) begin
        WD_addr <= launch_addr;
        WD      <= launch_data;
      end
      pending <= pending_next;
      if (violation) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: reset, ALU path, FIFO
// priority/ordering, scoreboard collision, violations and mid-flight reset.
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [7:0]  alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  chk_ra_addr;
  logic [4:0]  chk_rd_addr;
  logic        stall;
  logic        en_WD;
  logic [4:0]  WD_addr;
  logic [7:0]  WD;
  logic [31:0] pending;
  logic        err;

  int errors = 0;
  int checks = 0;
  logic [12:0] exp_q[$];

  writeback_unit #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk_ra_addr(chk_ra_addr), .chk_rd_addr(chk_rd_addr),
    .stall(stall), .en_WD(en_WD), .WD_addr(WD_addr), .WD(WD),
    .pending(pending), .err(err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    iss_valid = 0; iss_addr = 0;
    chk_ra_addr = 0; chk_rd_addr = 0;
  endtask

  task automatic issue(input logic [4:0] a);
    iss_valid = 1; iss_addr = a;
    tick();
    iss_valid = 0; iss_addr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    alu_valid = 1; alu_addr = 5'd2; alu_data = 8'h5A;
    mem_valid = 1; mem_addr = 5'd3; mem_data = 8'h3C;
    iss_valid = 1; iss_addr = 5'd4;
    tick();
    tick();
    checks++;
    if (en_WD !== 1'b0) begin errors++; $display("FAIL reset_en_WD got=%b exp=0", en_WD); end
    checks++;
    if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending got=%h exp=0", pending); end
    checks++;
    if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got=%b exp=1", mem_ready); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++;
    if ({WD_addr, WD} !== 13'd0) begin errors++; $display("FAIL reset_wd got=%h exp=0", {WD_addr, WD}); end
    idle_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_alu_path();
    issue(5'd5);
    checks++;
    if (pending !== 32'h0000_0020) begin errors++; $display("FAIL alu_issue_pending got=%h exp=00000020", pending); end
    alu_valid = 1; alu_addr = 5'd5; alu_data = 8'hA5; chk_ra_addr = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL alu_stall_N got=%b exp=1", stall); end
    tick();
    alu_valid = 0;
    #1;
    checks++;
    if ({en_WD, WD_addr, WD} !== {1'b1, 5'd5, 8'hA5}) begin
      errors++; $display("FAIL alu_write_N1 got=%b/%0d/%h exp=1/5/a5", en_WD, WD_addr, WD);
    end
    checks++;
    if (stall !== 1'b1 || pending[5] !== 1'b1) begin
      errors++; $display("FAIL alu_stall_N1 got=%b/%b exp=1/1", stall, pending[5]);
    end
    tick();
    checks++;
    if (pending[5] !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL alu_clear_N2 got=%b/%b exp=0/0", pending[5], stall);
    end
    checks++;
    if ({en_WD, WD_addr, WD} !== {1'b0, 5'd5, 8'hA5}) begin
      errors++; $display("FAIL alu_hold_N2 got=%b/%0d/%h exp=0/5/a5", en_WD, WD_addr, WD);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL alu_err got=%b exp=0", err); end
    chk_ra_addr = 0;
  endtask

  task automatic test_priority_fifo();
    logic [12:0] exp;
    logic        exp_ready;
    for (int r = 1; r <= 4; r++) issue(5'(r));
    for (int r = 9; r <= 14; r++) issue(5'(r));
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back({5'(9 + i), 8'(8'h90 + i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({5'(1 + i), 8'(8'h11 * (i + 1))});
    for (int i = 0; i < 10; i++) begin
      alu_valid = (i < 6);
      alu_addr  = 5'(9 + i);
      alu_data  = 8'(8'h90 + i);
      mem_valid = (i < 4);
      mem_addr  = 5'(1 + i);
      mem_data  = 8'(8'h11 * (i + 1));
      exp_ready = !(i >= 4 && i <= 6);
      if (i < 8) begin
        checks++;
        if (mem_ready !== exp_ready) begin
          errors++; $display("FAIL prio_mem_ready cyc=%0d got=%b exp=%b", i, mem_ready, exp_ready);
        end
      end
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({en_WD, WD_addr, WD} !== {1'b1, exp}) begin
        errors++; $display("FAIL prio_write cyc=%0d got=%b/%0d/%h exp=1/%0d/%h", i, en_WD, WD_addr, WD, exp[12:8], exp[7:0]);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (en_WD !== 1'b0 || pending !== 32'd0 || mem_ready !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL prio_drain got=%b/%h/%b/%b exp=0/0/1/0", en_WD, pending, mem_ready, err);
    end
  endtask

  task automatic test_collision();
    issue(5'd7);
    chk_rd_addr = 5'd7;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL coll_stall_rd got=%b exp=1", stall); end
    alu_valid = 1; alu_addr = 5'd7; alu_data = 8'h77;
    tick();
    alu_valid = 0;
    iss_valid = 1; iss_addr = 5'd7;
    checks++;
    if (en_WD !== 1'b1 || WD_addr !== 5'd7) begin
      errors++; $display("FAIL coll_write got=%b/%0d exp=1/7", en_WD, WD_addr);
    end
    tick();
    iss_valid = 0;
    checks++;
    if (pending !== 32'h0000_0080 || err !== 1'b0) begin
      errors++; $display("FAIL coll_set_wins got=%h/%b exp=00000080/0", pending, err);
    end
    alu_valid = 1; alu_addr = 5'd7; alu_data = 8'h78;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (pending !== 32'd0 || err !== 1'b0) begin
      errors++; $display("FAIL coll_cleanup got=%h/%b exp=0/0", pending, err);
    end
  endtask

  task automatic test_violations();
    issue(5'd3);
    issue(5'd3);
    checks++;
    if (err !== 1'b1 || pending[3] !== 1'b1) begin
      errors++; $display("FAIL viol_reissue got=%b/%b exp=1/1", err, pending[3]);
    end
    tick(); tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL viol_sticky got=%b exp=1", err); end
    do_reset();
    checks++;
    if (err !== 1'b0 || pending !== 32'd0) begin
      errors++; $display("FAIL viol_rst_clear got=%b/%h exp=0/0", err, pending);
    end
    alu_valid = 1; alu_addr = 5'd12; alu_data = 8'hC3;
    tick();
    idle_inputs();
    checks++;
    if ({en_WD, WD_addr, WD, err} !== {1'b1, 5'd12, 8'hC3, 1'b1}) begin
      errors++; $display("FAIL viol_alu_nonpending got=%b/%0d/%h/%b exp=1/12/c3/1", en_WD, WD_addr, WD, err);
    end
    tick();
    checks++;
    if (err !== 1'b1 || pending !== 32'd0) begin
      errors++; $display("FAIL viol_alu_sticky got=%b/%h exp=1/0", err, pending);
    end
    do_reset();
  endtask

  task automatic test_reset_midflight();
    for (int r = 20; r <= 22; r++) issue(5'(r));
    for (int r = 25; r <= 27; r++) issue(5'(r));
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_addr = 5'(25 + i); alu_data = 8'(8'hB0 + i);
      mem_valid = 1; mem_addr = 5'(20 + i); mem_data = 8'(8'hD0 + i);
      tick();
    end
    idle_inputs();
    checks++;
    if (en_WD !== 1'b1 || WD_addr !== 5'd27) begin
      errors++; $display("FAIL mid_pre_reset got=%b/%0d exp=1/27", en_WD, WD_addr);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (en_WD !== 1'b0 || pending !== 32'd0 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/1", en_WD, pending, mem_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (en_WD !== 1'b0) begin
        errors++; $display("FAIL mid_no_write cyc=%0d got=%b exp=0", i, en_WD);
      end
    end
    checks++;
    if (err !== 1'b0 || pending !== 32'd0) begin
      errors++; $display("FAIL mid_final got=%b/%h exp=0/0", err, pending);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_alu_path();
    test_priority_fifo();
    test_collision();
    test_violations();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
